// File: rtl/apb_pkg.sv
// apb_pkg: bus-phase encodings and default widths shared by the APB
// requester (apb_master) and the APB completer.
package apb_pkg;

  // Default bus widths; instances may override through their parameters.
  localparam int unsigned APB_DATAWIDTH = 32;
  localparam int unsigned APB_ADDWIDTH  = 32;

  // Bus-phase encoding. The completer decodes the same values, so the
  // encodings must not change.
  typedef logic [1:0] apb_state_t;
  localparam logic [1:0] ST_IDLE   = 2'b00;
  localparam logic [1:0] ST_SETUP  = 2'b01;
  localparam logic [1:0] ST_ACCESS = 2'b10;

  // psel is high in every phase except IDLE.
  function automatic logic state_selects(input apb_state_t st);
    return (st == ST_SETUP) || (st == ST_ACCESS);
  endfunction

  // penable is high only in the ACCESS phase.
  function automatic logic state_enables(input apb_state_t st);
    return (st == ST_ACCESS);
  endfunction

endpackage

// File: rtl/apb_master_if.sv
// apb_master_if: command/response handshake plus APB requester signals.
// The master modport is the requester's view. The slave modport is the
// view of whatever sits around it: the command source and the APB completer.
interface apb_master_if import apb_pkg::*; #(
  parameter int unsigned DATAWIDTH = APB_DATAWIDTH,
  parameter int unsigned ADDWIDTH  = APB_ADDWIDTH
) ();

  // Command side
  logic                 cmd_valid;
  logic                 cmd_ready;
  logic                 cmd_write;
  logic [ADDWIDTH-1:0]  cmd_addr;
  logic [DATAWIDTH-1:0] cmd_wdata;

  // Response side
  logic                 rsp_valid;
  logic [DATAWIDTH-1:0] rsp_rdata;
  logic                 rsp_err;

  // APB bus
  logic                 psel;
  logic                 penable;
  logic                 pwrite;
  logic [ADDWIDTH-1:0]  paddr;
  logic [DATAWIDTH-1:0] pwdata;
  logic                 pready;
  logic                 pslverr;
  logic [DATAWIDTH-1:0] prdata;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata,
    output cmd_ready,
    output rsp_valid, rsp_rdata, rsp_err,
    output psel, penable, pwrite, paddr, pwdata,
    input  pready, pslverr, prdata
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata,
    input  cmd_ready,
    input  rsp_valid, rsp_rdata, rsp_err,
    input  psel, penable, pwrite, paddr, pwdata,
    output pready, pslverr, prdata
  );

endinterface

// File: rtl/apb_cmd_fifo.sv
// apb_cmd_fifo: synchronous command queue. The full and empty flags are
// registered, so the ready indication upstream has no combinational path
// from push or pop.
module apb_cmd_fifo import apb_pkg::*; #(
  parameter int unsigned WIDTH = 1 + APB_ADDWIDTH + APB_DATAWIDTH,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  output logic             full_o,
  input  logic             pop_i,
  output logic [WIDTH-1:0] pop_data_o,
  output logic             empty_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             full_q;
  logic             empty_q;
  logic             push_s;
  logic             pop_s;

  // A push into a full queue and a pop from an empty one are dropped.
  assign push_s = push_i && !full_q;
  assign pop_s  = pop_i && !empty_q;

  // Next pointers and occupancy. Pointers wrap because DEPTH is a power of two.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_s) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push_s, pop_s})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointer, count and flag registers. The flags are computed from the
  // next count so they always agree with count_q.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= (count_d == CNT_FULL);
      empty_q  <= (count_d == '0);
    end
  end

  // Storage array, cleared on reset so no stale command can leak out.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
    end else if (push_s) begin
      mem_q[wr_ptr_q] <= push_data_i;
    end
  end

  assign pop_data_o = mem_q[rd_ptr_q];
  assign full_o     = full_q;
  assign empty_o    = empty_q;

endmodule

// File: rtl/apb_master.sv
// apb_master: accepts read/write commands into a small queue and runs them
// on APB as IDLE -> SETUP -> ACCESS transfers. Back-to-back commands keep
// psel asserted. A transfer ends when the completer raises pready or when
// the wait-state limit is reached. Each transfer produces one rsp_valid pulse.
module apb_master import apb_pkg::*; #(
  parameter int unsigned DATAWIDTH  = APB_DATAWIDTH,
  parameter int unsigned ADDWIDTH   = APB_ADDWIDTH,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned TIMEOUT    = 16
) (
  input  logic         clk,
  input  logic         rst,
  apb_master_if.master bus
);

  localparam int unsigned CMD_W  = 1 + ADDWIDTH + DATAWIDTH;
  localparam int unsigned WAIT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam bit          TMO_EN = (TIMEOUT != 0);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

  // Command queue interface
  logic [CMD_W-1:0]     cmd_in_s;
  logic [CMD_W-1:0]     head_s;
  logic                 fifo_full_s;
  logic                 fifo_empty_s;
  logic                 fifo_pop_s;
  logic                 head_write_s;
  logic [ADDWIDTH-1:0]  head_addr_s;
  logic [DATAWIDTH-1:0] head_wdata_s;

  // Transfer-end qualifiers
  logic                 access_s;
  logic                 done_s;
  logic                 tmo_s;
  logic                 finish_s;

  // State and output registers
  apb_state_t           state_q, state_d;
  logic                 psel_q, psel_d;
  logic                 penable_q, penable_d;
  logic                 pwrite_q, pwrite_d;
  logic [ADDWIDTH-1:0]  paddr_q, paddr_d;
  logic [DATAWIDTH-1:0] pwdata_q, pwdata_d;
  logic                 rsp_valid_q, rsp_valid_d;
  logic                 rsp_err_q, rsp_err_d;
  logic [DATAWIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
  logic [WAIT_W-1:0]    wait_q, wait_d;

  assign cmd_in_s     = {bus.cmd_write, bus.cmd_addr, bus.cmd_wdata};
  assign head_write_s = head_s[CMD_W-1];
  assign head_addr_s  = head_s[DATAWIDTH +: ADDWIDTH];
  assign head_wdata_s = head_s[DATAWIDTH-1:0];

  apb_cmd_fifo #(
    .WIDTH (CMD_W),
    .DEPTH (FIFO_DEPTH)
  ) u_cmd_fifo (
    .clk         (clk),
    .rst         (rst),
    .push_i      (bus.cmd_valid),
    .push_data_i (cmd_in_s),
    .full_o      (fifo_full_s),
    .pop_i       (fifo_pop_s),
    .pop_data_o  (head_s),
    .empty_o     (fifo_empty_s)
  );

  // A transfer ends on pready, or on the last allowed wait cycle without it.
  // prdata and pslverr are only looked at when done_s is true.
  assign access_s   = (state_q == ST_ACCESS);
  assign done_s     = access_s && bus.pready;
  assign tmo_s      = TMO_EN && access_s && !bus.pready && (wait_q == WAIT_LAST);
  assign finish_s   = done_s || tmo_s;
  assign fifo_pop_s = !fifo_empty_s && ((state_q == ST_IDLE) || finish_s);

  // Phase sequencing plus next values for the bus and response registers.
  always_comb begin
    state_d     = state_q;
    pwrite_d    = pwrite_q;
    paddr_d     = paddr_q;
    pwdata_d    = pwdata_q;
    rsp_valid_d = 1'b0;
    rsp_err_d   = 1'b0;
    rsp_rdata_d = '0;
    wait_d      = wait_q;

    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty_s) begin
          state_d = ST_SETUP;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SETUP: begin
        state_d = ST_ACCESS;
      end
      ST_ACCESS: begin
        if (finish_s) begin
          state_d = fifo_empty_s ? ST_IDLE : ST_SETUP;
        end else begin
          state_d = ST_ACCESS;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // The address phase is loaded only when a command leaves the queue,
    // so it holds through ACCESS and keeps its last value in IDLE.
    if (fifo_pop_s) begin
      pwrite_d = head_write_s;
      paddr_d  = head_addr_s;
      pwdata_d = head_wdata_s;
    end else begin
      pwrite_d = pwrite_q;
      paddr_d  = paddr_q;
      pwdata_d = pwdata_q;
    end

    // Read data is returned only for reads that end without an error.
    if (finish_s) begin
      rsp_valid_d = 1'b1;
      rsp_err_d   = tmo_s || bus.pslverr;
      if (done_s && !pwrite_q && !bus.pslverr) begin
        rsp_rdata_d = bus.prdata;
      end else begin
        rsp_rdata_d = '0;
      end
    end else begin
      rsp_valid_d = 1'b0;
      rsp_err_d   = 1'b0;
      rsp_rdata_d = '0;
    end

    // Wait counter: restarts with every SETUP and saturates so that it
    // cannot wrap when the limit is disabled.
    if (state_d == ST_SETUP) begin
      wait_d = '0;
    end else if (access_s && !bus.pready && (wait_q != '1)) begin
      wait_d = wait_q + WAIT_W'(1);
    end else begin
      wait_d = wait_q;
    end
  end

  assign psel_d    = state_selects(state_d);
  assign penable_d = state_enables(state_d);

  // State and registered outputs. Reset drops psel/penable at once and
  // suppresses any response for the transfer that was in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      pwrite_q    <= 1'b0;
      paddr_q     <= '0;
      pwdata_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
      wait_q      <= '0;
    end else begin
      state_q     <= state_d;
      psel_q      <= psel_d;
      penable_q   <= penable_d;
      pwrite_q    <= pwrite_d;
      paddr_q     <= paddr_d;
      pwdata_q    <= pwdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_rdata_q <= rsp_rdata_d;
      wait_q      <= wait_d;
    end
  end

  assign bus.cmd_ready = !fifo_full_s;
  assign bus.psel      = psel_q;
  assign bus.penable   = penable_q;
  assign bus.pwrite    = pwrite_q;
  assign bus.paddr     = paddr_q;
  assign bus.pwdata    = pwdata_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_err   = rsp_err_q;
  assign bus.rsp_rdata = rsp_rdata_q;

endmodule

// File: tb/tb_apb_master.sv
// tb_apb_master: directed single-transfer vectors from a table, plus
// hand-written sequences for queue back-pressure, back-to-back transfers
// and reset in the middle of a transfer.
module tb_apb_master;
  import apb_pkg::*;

  localparam int unsigned DW    = 32;
  localparam int unsigned AW    = 32;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned TMO   = 16;
  localparam int          NVEC  = 9;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  apb_master_if #(.DATAWIDTH(DW), .ADDWIDTH(AW)) bus ();

  apb_master #(
    .DATAWIDTH  (DW),
    .ADDWIDTH   (AW),
    .FIFO_DEPTH (DEPTH),
    .TIMEOUT    (TMO)
  ) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual 0x%0h required 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        write;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          wait_cycles;  // ACCESS cycles with pready low before it rises
    logic        slverr;
    logic [31:0] rdata;
    logic        exp_err;
    logic [31:0] exp_rdata;
    int          exp_access;   // expected ACCESS-phase length in cycles
  } vec_t;

  vec_t vecs [NVEC];

  // Run one command from IDLE through its response. Called at a negedge in IDLE.
  task automatic run_vec(input vec_t v, input int idx);
    int   acc;
    logic got;
    logic unstable;
    check($sformatf("v%0d_idle_psel", idx), 32'(bus.psel), 32'h0);
    bus.cmd_valid = 1'b1;
    bus.cmd_write = v.write;
    bus.cmd_addr  = v.addr;
    bus.cmd_wdata = v.wdata;
    bus.pready    = 1'b0;
    bus.pslverr   = 1'b1;
    bus.prdata    = 32'hBAD0BAD0;
    @(negedge clk);                         // push at edge N
    bus.cmd_valid = 1'b0;
    bus.cmd_addr  = ~v.addr;
    bus.cmd_wdata = ~v.wdata;
    check($sformatf("v%0d_lat_idle", idx), 32'(bus.psel), 32'h0);
    @(negedge clk);                         // SETUP after edge N+1
    check($sformatf("v%0d_setup_psel", idx), 32'(bus.psel), 32'h1);
    check($sformatf("v%0d_setup_penable", idx), 32'(bus.penable), 32'h0);
    check($sformatf("v%0d_setup_paddr", idx), bus.paddr, v.addr);
    check($sformatf("v%0d_setup_pwrite", idx), 32'(bus.pwrite), 32'(v.write));
    check($sformatf("v%0d_setup_pwdata", idx), bus.pwdata, v.wdata);
    bus.pready = (v.wait_cycles == 0);      // must not end the SETUP phase
    acc = 0;
    got = 1'b0;
    unstable = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (bus.rsp_valid) begin
        got = 1'b1;
        break;
      end
      if (bus.psel && bus.penable) begin
        acc++;
        if (bus.paddr !== v.addr || bus.pwrite !== v.write) unstable = 1'b1;
        if (acc > v.wait_cycles) begin
          bus.pready  = 1'b1;
          bus.pslverr = v.slverr;
          bus.prdata  = v.rdata;
        end else begin
          bus.pready  = 1'b0;
          bus.pslverr = 1'b1;
          bus.prdata  = 32'hBAD0BAD0;
        end
      end
    end
    check($sformatf("v%0d_rsp_valid", idx), 32'(got), 32'h1);
    check($sformatf("v%0d_rsp_err", idx), 32'(bus.rsp_err), 32'(v.exp_err));
    check($sformatf("v%0d_rsp_rdata", idx), bus.rsp_rdata, v.exp_rdata);
    check($sformatf("v%0d_access_len", idx), 32'(acc), 32'(v.exp_access));
    check($sformatf("v%0d_addr_stable", idx), 32'(unstable), 32'h0);
    check($sformatf("v%0d_done_psel", idx), 32'(bus.psel), 32'h0);
    check($sformatf("v%0d_idle_paddr_hold", idx), bus.paddr, v.addr);
    bus.pready  = 1'b0;
    bus.pslverr = 1'b0;
    bus.prdata  = 32'h0;
    @(negedge clk);
    check($sformatf("v%0d_rsp_pulse", idx), 32'(bus.rsp_valid), 32'h0);
  endtask

  // Hard stop in case something in the bench itself stalls.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Main test sequence.
  initial begin
    int   idx;
    logic rdy;
    int   nrsp;
    logic drop;
    int   setups;
    logic [31:0] expd;
    logic seen_rsp;
    logic seen_psel;

    //        write addr          wdata         wait slverr rdata         err   exp_rdata     acc
    vecs[0] = '{1'b1, 32'h00000010, 32'hDEADBEEF, 0,   1'b0, 32'h00000000, 1'b0, 32'h00000000, 1};
    vecs[1] = '{1'b0, 32'h00000010, 32'h00000000, 3,   1'b0, 32'h12345678, 1'b0, 32'h12345678, 4};
    vecs[2] = '{1'b0, 32'h00000020, 32'h00000000, 100, 1'b0, 32'h11111111, 1'b1, 32'h00000000, 16};
    vecs[3] = '{1'b0, 32'h00000030, 32'h00000000, 0,   1'b1, 32'hFFFFFFFF, 1'b1, 32'h00000000, 1};
    vecs[4] = '{1'b1, 32'h00000044, 32'h0BADF00D, 2,   1'b1, 32'h22222222, 1'b1, 32'h00000000, 3};
    vecs[5] = '{1'b0, 32'hFFFFFFFC, 32'h00000000, 0,   1'b0, 32'hA5A5A5A5, 1'b0, 32'hA5A5A5A5, 1};
    vecs[6] = '{1'b0, 32'h00000060, 32'h00000000, 15,  1'b0, 32'h5A5A0001, 1'b0, 32'h5A5A0001, 16};
    vecs[7] = '{1'b1, 32'h00000070, 32'hCAFEF00D, 100, 1'b0, 32'h33333333, 1'b1, 32'h00000000, 16};
    vecs[8] = '{1'b1, 32'h00000080, 32'h01020304, 0,   1'b0, 32'h44444444, 1'b0, 32'h00000000, 1};

    rst           = 1'b0;
    bus.cmd_valid = 1'b0;
    bus.cmd_write = 1'b0;
    bus.cmd_addr  = 32'h0;
    bus.cmd_wdata = 32'h0;
    bus.pready    = 1'b0;
    bus.pslverr   = 1'b0;
    bus.prdata    = 32'h0;
    @(negedge clk);
    @(negedge clk);
    check("rst_psel", 32'(bus.psel), 32'h0);
    check("rst_penable", 32'(bus.penable), 32'h0);
    check("rst_pwrite", 32'(bus.pwrite), 32'h0);
    check("rst_paddr", bus.paddr, 32'h0);
    check("rst_pwdata", bus.pwdata, 32'h0);
    check("rst_rsp_valid", 32'(bus.rsp_valid), 32'h0);
    check("rst_rsp_err", 32'(bus.rsp_err), 32'h0);
    check("rst_rsp_rdata", bus.rsp_rdata, 32'h0);
    check("rst_cmd_ready", 32'(bus.cmd_ready), 32'h1);
    rst = 1'b1;
    @(negedge clk);

    for (int i = 0; i < NVEC; i++) begin
      run_vec(vecs[i], i);
    end

    // Back-pressure: offer 8 reads while the first transfer is stalled.
    bus.pready  = 1'b0;
    bus.pslverr = 1'b0;
    idx = 0;
    for (int c = 0; c < 8; c++) begin
      bus.cmd_valid = 1'b1;
      bus.cmd_write = 1'b0;
      bus.cmd_addr  = 32'h100 + 32'(4 * idx);
      bus.cmd_wdata = 32'h0;
      rdy = bus.cmd_ready;
      @(negedge clk);
      if (rdy) idx++;
    end
    bus.cmd_valid = 1'b0;
    check("b2b_accepted", 32'(idx), 32'd5);
    check("b2b_cmd_ready_full", 32'(bus.cmd_ready), 32'h0);

    // Release the completer; the five transfers must run back-to-back.
    bus.pready = 1'b1;
    nrsp   = 0;
    drop   = 1'b0;
    setups = 0;
    for (int c = 0; c < 60 && nrsp < 5; c++) begin
      bus.prdata = {16'hC0DE, bus.paddr[15:0]};
      @(negedge clk);
      if (bus.rsp_valid) begin
        expd = {16'hC0DE, 16'h0100 + 16'(4 * nrsp)};
        check($sformatf("b2b_rdata%0d", nrsp), bus.rsp_rdata, expd);
        check($sformatf("b2b_err%0d", nrsp), 32'(bus.rsp_err), 32'h0);
        nrsp++;
      end
      if (nrsp < 5 && !bus.psel) drop = 1'b1;
      if (bus.psel && !bus.penable) setups++;
    end
    check("b2b_rsp_count", 32'(nrsp), 32'd5);
    check("b2b_psel_drop", 32'(drop), 32'h0);
    check("b2b_setup_cycles", 32'(setups), 32'd4);
    check("b2b_final_psel", 32'(bus.psel), 32'h0);
    check("b2b_ready_again", 32'(bus.cmd_ready), 32'h1);
    @(negedge clk);

    // Reset during ACCESS with two commands still queued.
    bus.pready = 1'b0;
    bus.prdata = 32'h0;
    for (int c = 0; c < 3; c++) begin
      bus.cmd_valid = 1'b1;
      bus.cmd_write = 1'b1;
      bus.cmd_addr  = 32'h200 + 32'(4 * c);
      bus.cmd_wdata = 32'h0;
      @(negedge clk);
    end
    bus.cmd_valid = 1'b0;
    check("rstmid_in_access", {30'h0, bus.psel, bus.penable}, 32'h3);
    #2;
    rst = 1'b0;
    #1;
    check("rstmid_psel", 32'(bus.psel), 32'h0);
    check("rstmid_penable", 32'(bus.penable), 32'h0);
    check("rstmid_cmd_ready", 32'(bus.cmd_ready), 32'h1);
    @(negedge clk);
    rst = 1'b1;
    bus.pready = 1'b1;
    seen_rsp  = 1'b0;
    seen_psel = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (bus.rsp_valid) seen_rsp = 1'b1;
      if (bus.psel) seen_psel = 1'b1;
    end
    check("rstmid_no_rsp", 32'(seen_rsp), 32'h0);
    check("rstmid_queue_dropped", 32'(seen_psel), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/apb_master.md
APB_MASTER -- requirements
Module: apb_master

Interface
REQ-001 Parameter DATAWIDTH, 32, width of pwdata/prdata/cmd_wdata/rsp_rdata.
REQ-002 Parameter ADDWIDTH, 32, width of paddr/cmd_addr.
REQ-003 Parameter FIFO_DEPTH, 4, command FIFO entries (power of two, >=2).
REQ-004 Parameter TIMEOUT, 16, max ACCESS cycles with pready low (0 = timeout disabled).
REQ-005 Reset rst SHALL be asynchronous, active-low; clock clk.
REQ-006 clk  input  1  rising-edge clock for all state.
REQ-007 rst  input  1  asynchronous active-low reset.
REQ-008 cmd_valid  input  1  command offered.
REQ-009 cmd_ready  output  1  FIFO can accept a command.
REQ-010 cmd_write  input  1  1=write, 0=read.
REQ-011 cmd_addr  input  ADDWIDTH  transfer address.
REQ-012 cmd_wdata  input  DATAWIDTH  write data (ignored for reads).
REQ-013 rsp_valid  output  1  one-cycle completion pulse.
REQ-014 rsp_rdata  output  DATAWIDTH  read data (0 for writes and errors).
REQ-015 rsp_err  output  1  transfer ended with pslverr or timeout.
REQ-016 psel, penable, pwrite  output  1 each  APB select, enable, direction.
REQ-017 paddr  output  ADDWIDTH; pwdata  output  DATAWIDTH  APB address/write data.
REQ-018 pready, pslverr  input  1 each; prdata  input  DATAWIDTH  APB completer response.

Function
REQ-019 Command accepted on rising edge where cmd_valid && cmd_ready; cmd_ready SHALL equal !full, derived from registered count only (no path from cmd_valid or pready).
REQ-020 Simultaneous push and pop SHALL leave count unchanged; push while full SHALL be ignored; pop only when non-empty.
REQ-021 FSM states IDLE, SETUP, ACCESS; IDLE: psel=0, penable=0; SETUP: psel=1, penable=0; ACCESS: psel=1, penable=1.
REQ-022 IDLE -> SETUP on the edge where FIFO non-empty, popping head into paddr/pwrite/pwdata registers at that edge.
REQ-023 SETUP -> ACCESS unconditionally after exactly one cycle.
REQ-024 ACCESS completes on an edge with pready=1; then -> SETUP (popping next command) if FIFO non-empty, else -> IDLE.
REQ-025 Back-to-back transfers SHALL keep psel high continuously, penable low for exactly one SETUP cycle between ACCESS phases.
REQ-026 paddr, pwrite, pwdata SHALL be stable from SETUP through completing ACCESS cycle; hold last value in IDLE.
REQ-027 Latency: command pushed into empty FIFO at edge N in IDLE -> SETUP cycle after edge N+1, ACCESS after N+2; with pready=1, rsp_valid high in cycle after edge N+3.
REQ-028 On completion, registered rsp_valid=1 for one cycle; rsp_err=pslverr; rsp_rdata=prdata for error-free reads, else 0.
REQ-029 Wait counter clears on entering SETUP, increments each ACCESS cycle with pready=0; when TIMEOUT!=0 and counter reaches TIMEOUT-1 with pready=0, transfer ends at that edge with rsp_err=1, rsp_rdata=0, same next-state rule as REQ-024.
REQ-030 prdata and pslverr SHALL be sampled only in ACCESS with pready=1; ignored otherwise.

Reset
REQ-031 While rst=0: state=IDLE, psel=0, penable=0, pwrite=0, paddr=0, pwdata=0, rsp_valid=0, rsp_err=0, rsp_rdata=0, FIFO empty (cmd_ready=1), wait counter=0.
REQ-032 Reset mid-transfer SHALL drop psel/penable immediately, discard in-flight and queued commands, and produce no rsp_valid.

Structure
REQ-033 Shared package apb_pkg SHALL hold state encoding (IDLE=2'b00, SETUP=2'b01, ACCESS=2'b10) and default DATAWIDTH/ADDWIDTH constants, shared with the APB completer.
REQ-034 Command queue SHALL be sub-module apb_cmd_fifo (synchronous, width 1+ADDWIDTH+DATAWIDTH, depth FIFO_DEPTH, clk/rst as above).

Verification
REQ-035 Write 0x10/0xDEADBEEF, pready tied 1 -> one SETUP cycle (psel=1, penable=0, paddr=0x10, pwrite=1), one ACCESS cycle, rsp_valid pulse with rsp_err=0, rsp_rdata=0.
REQ-036 Read 0x10, pready low 3 ACCESS cycles then high with prdata=0x12345678 -> ACCESS lasts 4 cycles, paddr stable, rsp_rdata=0x12345678, rsp_err=0.
REQ-037 cmd_valid held 1 for 8 cycles, pready=0 -> cmd_ready falls when 4 queued; then pready=1 -> 5 transfers back-to-back, psel never drops between them, 5 rsp_valid pulses in order.
REQ-038 TIMEOUT=16, pready stuck 0 -> ACCESS ends after 16 cycles, rsp_err=1, rsp_rdata=0, psel low next cycle.
REQ-039 Read with pready=1, pslverr=1, prdata=0xFFFFFFFF -> rsp_err=1, rsp_rdata=0.
REQ-040 rst asserted during ACCESS with 2 queued -> psel/penable 0 immediately, cmd_ready=1, no rsp_valid after release.
